// File: rtl/aes_dec_key_schedule.sv
// aes_dec_key_schedule
//   AES-128 key expansion for the decryption path. A cipher key is expanded into
//   round keys 0..10 (one per cycle) and held in an 11-entry store. The store is
//   then served to the inverse-round datapath in reverse order (10 down to 0).
// Ports
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   key_load     sample key_in and (re)start expansion from any state
//   key_in       cipher key, w0 in the most significant 32 bits
//   rk_req       request the next round key (reverse order), honoured in READY only
//   rk_rewind    move the read pointer back to round 10 (beats rk_req)
//   busy         expansion in progress
//   ready        all round keys stored, requests accepted
//   rk_valid     single-cycle pulse, rk_out/rk_idx valid
//   rk_out       round key
//   rk_idx       round index of rk_out
//   rk_last      rk_valid for round 0
module aes_dec_key_schedule #(
  parameter int NR    = 10,
  parameter int KEY_W = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_load,
  input  logic [KEY_W-1:0] key_in,
  input  logic             rk_req,
  input  logic             rk_rewind,
  output logic             busy,
  output logic             ready,
  output logic             rk_valid,
  output logic [KEY_W-1:0] rk_out,
  output logic [3:0]       rk_idx,
  output logic             rk_last
);

  localparam logic [3:0] LAST_IDX = 4'(NR);
  localparam logic [3:0] LAST_CNT = 4'(NR - 1);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  state_t           state, state_next;
  logic [KEY_W-1:0] store [0:NR];
  logic [3:0]       cnt;
  logic [3:0]       ptr;
  logic [3:0]       wr_idx;
  logic [KEY_W-1:0] prev_rk, next_rk;
  logic [31:0]      w0, w1, w2, w3, rot, t, w4, w5, w6, w7;

  // One expansion round: slot cnt -> slot cnt+1 with Rcon index cnt.
  always_comb begin
    prev_rk = store[cnt];
    w0      = prev_rk[127:96];
    w1      = prev_rk[95:64];
    w2      = prev_rk[63:32];
    w3      = prev_rk[31:0];
    rot     = {w3[23:0], w3[31:24]};
    t       = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]}
              ^ {rcon(cnt), 24'h0};
    w4      = w0 ^ t;
    w5      = w4 ^ w1;
    w6      = w5 ^ w2;
    w7      = w6 ^ w3;
    next_rk = {w4, w5, w6, w7};
    wr_idx  = cnt + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (key_load) state_next = EXPAND;
      EXPAND:  if (!key_load && cnt == LAST_CNT) state_next = READY;
      READY:   if (key_load) state_next = EXPAND;
      default: state_next = IDLE;
    endcase
  end

  // Key store has no reset; its contents are only read after a full expansion.
  always_ff @(posedge clk) begin
    if (key_load)              store[0]      <= key_in;
    else if (state == EXPAND)  store[wr_idx] <= next_rk;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      ready    <= 1'b0;
      rk_valid <= 1'b0;
      rk_last  <= 1'b0;
      rk_out   <= '0;
      rk_idx   <= '0;
      cnt      <= '0;
      ptr      <= '0;
    end else begin
      rk_valid <= 1'b0;
      rk_last  <= 1'b0;
      if (key_load) begin
        // Restart from any state; a same-edge rk_req is dropped.
        cnt   <= '0;
        busy  <= 1'b1;
        ready <= 1'b0;
      end else begin
        case (state)
          EXPAND: begin
            cnt <= cnt + 4'd1;
            if (cnt == LAST_CNT) begin
              busy  <= 1'b0;
              ready <= 1'b1;
              ptr   <= LAST_IDX;
            end
          end
          READY: begin
            if (rk_rewind) begin
              ptr <= LAST_IDX;
            end else if (rk_req) begin
              rk_valid <= 1'b1;
              rk_out   <= store[ptr];
              rk_idx   <= ptr;
              rk_last  <= (ptr == 4'd0);
              ptr      <= (ptr == 4'd0) ? LAST_IDX : ptr - 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_dec_key_schedule.sv
// Self-checking bench for aes_dec_key_schedule. The reference builds the S-box
// from GF(2^8) inversion plus the affine map, and expands keys with the textbook
// 44-word recurrence.
module tb_aes_dec_key_schedule;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_load = 1'b0;
  logic [127:0] key_in = '0;
  logic         rk_req = 1'b0;
  logic         rk_rewind = 1'b0;
  logic         busy, ready, rk_valid, rk_last;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;

  aes_dec_key_schedule #(.NR(10), .KEY_W(128)) dut (
    .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_in(key_in),
    .rk_req(rk_req), .rk_rewind(rk_rewind), .busy(busy), .ready(ready),
    .rk_valid(rk_valid), .rk_out(rk_out), .rk_idx(rk_idx), .rk_last(rk_last)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  logic [7:0]   sbox_m [256];
  logic [127:0] rk_model [11];
  logic [127:0] got_rk [11];
  int           exp_ptr;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand_model(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]}
              ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) rk_model[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Pulses key_load for one edge; returns at the negedge right after the load edge.
  task automatic load_key(input logic [127:0] k);
    @(negedge clk);
    key_in   = k;
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    expand_model(k);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    exp_ptr = 10;
  endtask

  // Issues n back-to-back requests starting at the current negedge.
  task automatic read_seq(input int n, input string tag);
    rk_req = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == n - 1) rk_req = 1'b0;
      check($sformatf("%s_valid%0d", tag, i), 128'(rk_valid), 128'd1);
      check($sformatf("%s_idx%0d", tag, i), 128'(rk_idx), 128'(exp_ptr));
      check($sformatf("%s_key%0d", tag, i), rk_out, rk_model[exp_ptr]);
      check($sformatf("%s_last%0d", tag, i), 128'(rk_last), 128'(exp_ptr == 0));
      got_rk[exp_ptr] = rk_out;
      exp_ptr = (exp_ptr == 0) ? 10 : exp_ptr - 1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out"}, rk_out, '0);
    check({tag, "_flags"}, 128'({busy, ready, rk_valid, rk_last, rk_idx}), '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic saw;
    logic [127:0] k;
    build_sbox();

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Test 1: FIPS-197 example key
    load_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    check("t1_busy", 128'(busy), 128'd1);
    wait_ready(n);
    check("t1_latency", 128'(n), 128'd10);
    check("t1_busy_done", 128'(busy), 128'd0);
    read_seq(11, "t1");
    check("t1_r10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("t1_r1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("t1_r0", got_rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

    // Test 2: zero key, latency, wrap, hold after pulse
    load_key('0);
    wait_ready(n);
    check("t2_latency", 128'(n), 128'd10);
    read_seq(12, "t2");
    check("t2_r10", got_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    check("t2_r1", got_rk[1], 128'h62636363626363636263636362636363);
    @(negedge clk);
    check("t2_valid_drop", 128'(rk_valid), 128'd0);
    check("t2_last_drop", 128'(rk_last), 128'd0);
    check("t2_out_hold", rk_out, rk_model[10]);
    check("t2_idx_hold", 128'(rk_idx), 128'd10);

    // Test 3: rewind beats a simultaneous request
    load_key({$urandom, $urandom, $urandom, $urandom});
    wait_ready(n);
    read_seq(3, "t3a");
    rk_rewind = 1'b1;
    rk_req    = 1'b1;
    @(negedge clk);
    rk_rewind = 1'b0;
    rk_req    = 1'b0;
    check("t3_rewind_novalid", 128'(rk_valid), 128'd0);
    exp_ptr = 10;
    read_seq(1, "t3b");

    // Test 4: reload mid-expansion; requests while busy are ignored
    load_key({$urandom, $urandom, $urandom, $urandom});
    repeat (4) @(negedge clk);
    load_key({$urandom, $urandom, $urandom, $urandom});
    rk_req = 1'b1;
    saw = 1'b0;
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
      if (rk_valid) saw = 1'b1;
    end
    rk_req = 1'b0;
    exp_ptr = 10;
    check("t4_latency", 128'(n), 128'd10);
    check("t4_busy_req", 128'(saw), 128'd0);
    read_seq(11, "t4");

    // Reload in READY with a same-edge request
    k = {$urandom, $urandom, $urandom, $urandom};
    key_in   = k;
    key_load = 1'b1;
    rk_req   = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    rk_req   = 1'b0;
    expand_model(k);
    check("rl_novalid", 128'(rk_valid), 128'd0);
    check("rl_ready", 128'(ready), 128'd0);
    check("rl_busy", 128'(busy), 128'd1);
    wait_ready(n);
    check("rl_latency", 128'(n), 128'd10);
    read_seq(11, "rl");

    // Test 5: asynchronous reset mid-EXPAND and mid-READY
    load_key({$urandom, $urandom, $urandom, $urandom});
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("t5_exp");
    @(negedge clk);
    rst_n  = 1'b1;
    rk_req = 1'b1;
    saw = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (rk_valid || ready) saw = 1'b1;
    end
    rk_req = 1'b0;
    check("t5_exp_ignored", 128'(saw), 128'd0);

    load_key({$urandom, $urandom, $urandom, $urandom});
    wait_ready(n);
    check("t5_latency", 128'(n), 128'd10);
    read_seq(2, "t5");
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("t5_rdy");
    @(negedge clk);
    rst_n  = 1'b1;
    rk_req = 1'b1;
    saw = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rk_valid || ready) saw = 1'b1;
    end
    rk_req = 1'b0;
    check("t5_rdy_ignored", 128'(saw), 128'd0);

    // Randomized keys, full reverse read each
    for (int r = 0; r < 4; r++) begin
      load_key({$urandom, $urandom, $urandom, $urandom});
      wait_ready(n);
      check($sformatf("rnd%0d_latency", r), 128'(n), 128'd10);
      read_seq(11, $sformatf("rnd%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
